// File: rtl/i2c_slave_controller.sv
// I2C slave protocol controller: sequences address match, RX/TX byte phases and
// ACK/NACK handling from bit-timer status levels, driving shift-register and FIFO strobes.
module i2c_slave_controller #(
    parameter bit GENERAL_CALL_EN = 1'b0
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start_found,
    input  logic       stop_found,
    input  logic       byte_received,
    input  logic       ack_prep,
    input  logic       ack_check,
    input  logic       ack_done,
    input  logic [7:0] rx_data,
    input  logic [6:0] bus_address,
    input  logic       sda_in,
    input  logic       tx_empty,
    input  logic       rx_full,
    output logic       rx_enable,
    output logic       tx_enable,
    output logic       load_data,
    output logic [1:0] sda_mode,
    output logic       rw_mode,
    output logic       rx_w_enable,
    output logic       tx_r_enable,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR_RX,
        ADDR_CHECK,
        ADDR_ACK,
        RX_DATA,
        RX_STORE,
        RX_ACK,
        RX_NACK,
        TX_LOAD,
        TX_SEND,
        TX_ACKWAIT,
        TX_ACKED,
        IGNORE
    } state_t;

    localparam logic [1:0] SDA_RELEASE = 2'b00;
    localparam logic [1:0] SDA_LOW     = 2'b01;
    localparam logic [1:0] SDA_HIGH    = 2'b10;
    localparam logic [1:0] SDA_TX      = 2'b11;

    state_t r_state;
    state_t w_next_state;
    logic   r_rw_mode;
    logic   w_addr_match;
    logic   w_unused;

    // Byte completion is tracked through ack_prep; byte_received is not needed here.
    assign w_unused = byte_received;

    assign w_addr_match = (rx_data[7:1] == bus_address) ||
                          (GENERAL_CALL_EN && (rx_data == 8'h00));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= IDLE;
            r_rw_mode <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ADDR_CHECK && w_addr_match) begin
                r_rw_mode <= rx_data[0];
            end
        end
    end

    assign rw_mode = r_rw_mode;

    always_comb begin
        w_next_state = r_state;
        rx_enable    = 1'b0;
        tx_enable    = 1'b0;
        load_data    = 1'b0;
        sda_mode     = SDA_RELEASE;
        rx_w_enable  = 1'b0;
        tx_r_enable  = 1'b0;
        busy         = (r_state != IDLE);

        case (r_state)
            IDLE: begin
                if (start_found) w_next_state = ADDR_RX;
            end
            ADDR_RX: begin
                rx_enable = 1'b1;
                if (ack_prep) w_next_state = ADDR_CHECK;
            end
            ADDR_CHECK: begin
                w_next_state = w_addr_match ? ADDR_ACK : IGNORE;
            end
            ADDR_ACK: begin
                sda_mode = SDA_LOW;
                if (ack_done) w_next_state = r_rw_mode ? TX_LOAD : RX_DATA;
            end
            RX_DATA: begin
                rx_enable = 1'b1;
                if (ack_prep) w_next_state = RX_STORE;
            end
            RX_STORE: begin
                // A full FIFO drops the byte and the master is told so with a NACK.
                rx_w_enable  = !rx_full;
                w_next_state = rx_full ? RX_NACK : RX_ACK;
            end
            RX_ACK: begin
                sda_mode = SDA_LOW;
                if (ack_done) w_next_state = RX_DATA;
            end
            RX_NACK: begin
                sda_mode = SDA_HIGH;
                if (ack_done) w_next_state = IGNORE;
            end
            TX_LOAD: begin
                load_data    = 1'b1;
                tx_r_enable  = !tx_empty;
                w_next_state = TX_SEND;
            end
            TX_SEND: begin
                tx_enable = 1'b1;
                sda_mode  = SDA_TX;
                if (ack_prep) w_next_state = TX_ACKWAIT;
            end
            TX_ACKWAIT: begin
                if (ack_check) w_next_state = sda_in ? IGNORE : TX_ACKED;
            end
            TX_ACKED: begin
                if (ack_done) w_next_state = TX_LOAD;
            end
            IGNORE: begin
                w_next_state = r_state;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        // Bus conditions pre-empt everything; STOP beats a coincident START.
        if (r_state != IDLE) begin
            if (start_found) w_next_state = ADDR_RX;
            if (stop_found)  w_next_state = IDLE;
        end
    end

endmodule
